// File: rtl/fp24_recip.sv
// fp24 reciprocal using Newton-Raphson iterations y <- y * (2 - x*y).
// One multiplier and one adder are shared across all iterations.

module fp24_mult (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  output logic [23:0] p_o
);
  logic [33:0]       prod;
  logic [15:0]       mant;
  logic              rnd;
  logic              sticky;
  logic [16:0]       mant_r;
  logic signed [9:0] exp_s;

  always_comb begin
    prod  = {1'b1, a_i[15:0]} * {1'b1, b_i[15:0]};
    exp_s = $signed({3'b000, a_i[22:16]}) + $signed({3'b000, b_i[22:16]}) - 10'sd63;
    if (prod[33]) begin
      mant   = prod[32:17];
      rnd    = prod[16];
      sticky = |prod[15:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      mant   = prod[31:16];
      rnd    = prod[15];
      sticky = |prod[14:0];
    end
    // round to nearest even; a carry out means the mantissa wrapped to 1.0
    mant_r = {1'b0, mant} + {16'h0000, rnd & (sticky | mant[0])};
    if (mant_r[16]) begin
      exp_s = exp_s + 10'sd1;
    end else begin
      exp_s = exp_s;
    end
    if ((a_i[22:16] == 7'h00) || (b_i[22:16] == 7'h00) || (exp_s <= 10'sd0)) begin
      p_o = {a_i[23] ^ b_i[23], 23'h000000};
    end else if (exp_s >= 10'sd127) begin
      p_o = {a_i[23] ^ b_i[23], 7'h7F, 16'h0000};
    end else begin
      p_o = {a_i[23] ^ b_i[23], exp_s[6:0], mant_r[15:0]};
    end
  end
endmodule

module fp24_add (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic        is_sub_i,
  output logic [23:0] s_o
);
  logic [23:0]       b_eff;
  logic [23:0]       lg;
  logic [23:0]       sm;
  logic [24:0]       ml;
  logic [24:0]       ms;
  logic [6:0]        diff;
  logic [25:0]       sum;
  logic [25:0]       norm;
  logic [4:0]        lead;
  logic [16:0]       mant_r;
  logic signed [9:0] exp_s;

  always_comb begin
    b_eff = {b_i[23] ^ is_sub_i, b_i[22:0]};
    if (a_i[22:0] >= b_eff[22:0]) begin
      lg = a_i;
      sm = b_eff;
    end else begin
      lg = b_eff;
      sm = a_i;
    end
    ml   = (lg[22:16] != 7'h00) ? {1'b1, lg[15:0], 8'h00} : 25'h0000000;
    diff = lg[22:16] - sm[22:16];
    ms   = (sm[22:16] == 7'h00) ? 25'h0000000 :
           (diff > 7'd24)       ? 25'h0000000 : ({1'b1, sm[15:0], 8'h00} >> diff);
    if (lg[23] == sm[23]) begin
      sum = {1'b0, ml} + {1'b0, ms};
    end else begin
      sum = {1'b0, ml} - {1'b0, ms};
    end
    lead = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (sum[i]) begin
        lead = i[4:0];
      end else begin
        lead = lead;
      end
    end
    // leading one lands in norm[25]; it stays clear only for a zero sum
    norm   = sum << (5'd25 - lead);
    mant_r = {1'b0, norm[24:9]} + {16'h0000, norm[8] & ((|norm[7:0]) | norm[9])};
    exp_s  = $signed({3'b000, lg[22:16]}) + $signed({5'b00000, lead}) - 10'sd24
           + (mant_r[16] ? 10'sd1 : 10'sd0);
    if (!norm[25]) begin
      s_o = 24'h000000;
    end else if (exp_s <= 10'sd0) begin
      s_o = {lg[23], 23'h000000};
    end else if (exp_s >= 10'sd127) begin
      s_o = {lg[23], 7'h7F, 16'h0000};
    end else begin
      s_o = {lg[23], exp_s[6:0], mant_r[15:0]};
    end
  end
endmodule

module fp24_recip #(
  parameter int          N_ITER = 3,
  parameter logic [22:0] MAGIC  = 23'h7DF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] x,
  input  logic        x_valid,
  output logic        x_ready,
  output logic [23:0] recip,
  output logic        recip_valid,
  input  logic        recip_ready,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, MUL_XY, SUB, MUL_Y, DONE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        s_q;
  logic        zero_q;
  logic        inf_q;
  logic [23:0] m_q;
  logic [23:0] y_q;
  logic [23:0] t_q;
  logic [23:0] recip_q;
  logic        recip_valid_q;
  logic        x_ready_q;
  logic        busy_q;
  logic [23:0] mul_a_d;
  logic [23:0] mul_b_d;
  logic [23:0] mul_p;
  logic [23:0] add_s;

  // Shared multiplier computes m*y in MUL_XY and y*t in MUL_Y.
  always_comb begin
    if (state_q == MUL_Y) begin
      mul_a_d = y_q;
      mul_b_d = t_q;
    end else begin
      mul_a_d = m_q;
      mul_b_d = y_q;
    end
  end

  fp24_mult u_mult (.a_i(mul_a_d), .b_i(mul_b_d), .p_o(mul_p));
  fp24_add  u_add  (.a_i(24'h400000), .b_i(t_q), .is_sub_i(1'b1), .s_o(add_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      s_q           <= 1'b0;
      zero_q        <= 1'b0;
      inf_q         <= 1'b0;
      m_q           <= 24'h000000;
      y_q           <= 24'h000000;
      t_q           <= 24'h000000;
      recip_q       <= 24'h000000;
      recip_valid_q <= 1'b0;
      x_ready_q     <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (x_valid) begin
            s_q       <= x[23];
            m_q       <= {1'b0, x[22:0]};
            y_q       <= {1'b0, MAGIC - x[22:0]};
            zero_q    <= (x[22:16] == 7'h00);
            inf_q     <= (x[22:16] == 7'h7F);
            cnt_q     <= 3'd0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= MUL_XY;
          end
        end
        MUL_XY: begin
          t_q     <= mul_p;
          state_q <= SUB;
        end
        SUB: begin
          t_q     <= add_s;
          state_q <= MUL_Y;
        end
        MUL_Y: begin
          y_q   <= mul_p;
          cnt_q <= cnt_q + 3'd1;
          if ((cnt_q + 3'd1) == 3'(N_ITER)) begin
            recip_q       <= zero_q ? {s_q, 7'h7F, 16'h0000} :
                             inf_q  ? {s_q, 23'h000000} : {s_q, mul_p[22:0]};
            recip_valid_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            state_q <= MUL_XY;
          end
        end
        DONE: begin
          if (recip_ready) begin
            recip_valid_q <= 1'b0;
            x_ready_q     <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          recip_valid_q <= 1'b0;
          x_ready_q     <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign x_ready     = x_ready_q;
  assign recip       = recip_q;
  assign recip_valid = recip_valid_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_fp24_recip.sv
// Directed-vector bench for fp24_recip: table of operands plus
// hand-written backpressure, reset and protocol sequences.

module tb_fp24_recip;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] x;
  logic        x_valid;
  logic        x_ready;
  logic [23:0] recip;
  logic        recip_valid;
  logic        recip_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] x;
    logic [23:0] exp_r;
    int          tol;
    string       name;
  } vec_t;

  vec_t vecs[14];

  fp24_recip dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .recip(recip), .recip_valid(recip_valid), .recip_ready(recip_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp_v, input int tol);
    int d;
    d = int'(act) - int'(exp_v);
    if (d < 0) d = -d;
    tests++;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (tol %0d)", name, act, exp_v, tol);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!recip_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [23:0] xin, output logic [23:0] res, output int lat);
    int n;
    n = 0;
    x = xin;
    x_valid = 1'b1;
    while (!x_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    x_valid = 1'b0;
    wait_valid(lat);
    res = recip;
    tick();
  endtask

  initial begin
    logic [23:0] res;
    logic [23:0] held;
    int lat;
    int seen;

    vecs[0]  = '{24'h3F0000, 24'h3F0000, 2, "one"};
    vecs[1]  = '{24'h400000, 24'h3E0000, 2, "two"};
    vecs[2]  = '{24'hC10000, 24'hBD0000, 2, "neg_four"};
    vecs[3]  = '{24'h410000, 24'h3D0000, 2, "four"};
    vecs[4]  = '{24'h000000, 24'h7F0000, 0, "pos_zero"};
    vecs[5]  = '{24'h800000, 24'hFF0000, 0, "neg_zero"};
    vecs[6]  = '{24'h7F0000, 24'h000000, 0, "pos_inf"};
    vecs[7]  = '{24'h00ABCD, 24'h7F0000, 0, "denormal"};
    vecs[8]  = '{24'hFF1234, 24'h800000, 0, "neg_inf"};
    vecs[9]  = '{24'h3F8000, 24'h3E5555, 2, "one_half"};
    vecs[10] = '{24'h3E8000, 24'h3F5555, 2, "three_qtr"};
    vecs[11] = '{24'h408000, 24'h3D5555, 2, "three"};
    vecs[12] = '{24'hBF8000, 24'hBE5555, 2, "neg_one_half"};
    vecs[13] = '{24'h010000, 24'h7D0000, 2, "min_exp"};

    rst = 1'b1;
    x = 24'h000000;
    x_valid = 1'b0;
    recip_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 24'(recip_valid), 24'h0, 0);
    check("rst_recip", recip, 24'h000000, 0);
    check("rst_busy", 24'(busy), 24'h0, 0);
    rst = 1'b0;
    tick();
    check("rst_x_ready", 24'(x_ready), 24'h1, 0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].x, res, lat);
      check({vecs[i].name, "_lat"}, 24'(lat), 24'd9, 0);
      check(vecs[i].name, res, vecs[i].exp_r, vecs[i].tol);
    end

    // Backpressure: result held for 5 cycles, consume edge must not accept.
    recip_ready = 1'b0;
    x = 24'h400000;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    wait_valid(lat);
    check("bp_lat", 24'(lat), 24'd9, 0);
    held = recip;
    check("bp_value", held, 24'h3E0000, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_stable", recip, held, 0);
      check("bp_valid_held", 24'(recip_valid), 24'h1, 0);
      check("bp_x_ready_low", 24'(x_ready), 24'h0, 0);
    end
    recip_ready = 1'b1;
    x = 24'h3F0000;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    check("bp_consumed", 24'(recip_valid), 24'h0, 0);
    check("bp_x_ready", 24'(x_ready), 24'h1, 0);
    check("bp_no_accept", 24'(busy), 24'h0, 0);
    tick();
    check("bp_still_idle", 24'(busy), 24'h0, 0);

    // Reset mid-operation abandons the result; x_valid during rst is ignored.
    x = 24'h400000;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    x_valid = 1'b1;
    tick();
    check("mid_rst_valid", 24'(recip_valid), 24'h0, 0);
    check("mid_rst_recip", recip, 24'h000000, 0);
    check("mid_rst_busy", 24'(busy), 24'h0, 0);
    rst = 1'b0;
    x_valid = 1'b0;
    tick();
    check("post_rst_ready", 24'(x_ready), 24'h1, 0);
    check("rst_no_accept", 24'(busy), 24'h0, 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (recip_valid) seen++;
    end
    check("rst_no_result", 24'(seen), 24'd0, 0);
    run_op(24'h410000, res, lat);
    check("post_rst_lat", 24'(lat), 24'd9, 0);
    check("post_rst_four", res, 24'h3D0000, 2);

    // x_valid held with changing x while busy: only the first value counts.
    recip_ready = 1'b0;
    x = 24'h400000;
    x_valid = 1'b1;
    tick();
    lat = 0;
    while (!recip_valid && lat < 40) begin
      case (lat % 3)
        0: x = 24'h000000;
        1: x = 24'h7F0000;
        default: x = 24'hC10000;
      endcase
      tick();
      lat++;
    end
    check("proto_lat", 24'(lat), 24'd9, 0);
    check("proto_first_value", recip, 24'h3E0000, 2);
    x_valid = 1'b0;
    recip_ready = 1'b1;
    tick();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (recip_valid) seen++;
      tick();
    end
    check("proto_one_result", 24'(seen), 24'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp24_recip.md
FP24_RECIP -- requirements
Module: fp24_recip

Interface
REQ-001 Parameter N_ITER, default 3: number of Newton-Raphson iterations, legal range 1..7.
REQ-002 Parameter MAGIC, default 23'h7DF000: seed constant applied to the magnitude bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 x  input  24  fp24 operand: sign [23], exponent [22:16] (bias 63), mantissa [15:0].
REQ-006 x_valid  input  1  operand valid.
REQ-007 x_ready  output  1  block can accept an operand.
REQ-008 recip  output  24  fp24 result, approximately 1/x.
REQ-009 recip_valid  output  1  result valid.
REQ-010 recip_ready  input  1  downstream accepts the result.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, MUL_XY, SUB, MUL_Y and DONE.
REQ-013 x_ready SHALL be high exactly when the state is IDLE.
REQ-014 Accept occurs when x_valid and x_ready are both high at a clock edge. On accept:
  - register s = x[23] and m = {1'b0, x[22:0]};
  - register seed y = MAGIC - x[22:0], as 23-bit magnitude with sign 0;
  - clear the iteration counter;
  - move to MUL_XY.
REQ-015 MUL_XY: t <= m * y using one shared fp24_mult; move to SUB.
REQ-016 SUB: t <= 2.0 (24'h400000) - t using one shared fp24_add with is_sub=1; move to MUL_Y.
REQ-017 MUL_Y: y <= y * t using the same shared fp24_mult; increment the counter.
  - If the counter reaches N_ITER, move to DONE.
  - Otherwise move to MUL_XY.
REQ-018 The block SHALL contain exactly one fp24_mult and one fp24_add, both combinational. It SHALL NOT unroll the iterations.
REQ-019 recip_valid SHALL be high exactly in DONE. It rises 3*N_ITER cycles after the accept edge (9 with defaults).
REQ-020 recip SHALL be {s, y[22:0]}, except for the special cases in REQ-021 and REQ-022.
REQ-021 If the accepted exponent is 7'h00 (zero or denormal), recip SHALL be {s, 7'h7F, 16'h0000} (signed infinity) with the same latency.
REQ-022 If the accepted exponent is 7'h7F (infinity), recip SHALL be {s, 23'h0} (signed zero) with the same latency.
REQ-023 recip and recip_valid SHALL hold stable in DONE until recip_ready is high at an edge; the FSM then returns to IDLE.
REQ-024 The block SHALL NOT accept a new operand in the cycle the result is consumed; the next accept is earliest one edge later.
REQ-025 x_valid while not in IDLE SHALL be ignored. The registered operand SHALL NOT change during an operation.
REQ-026 Precision: with the default parameters and a normal operand, recip SHALL be within ±2 mantissa LSB of the correctly rounded 1/x.
REQ-027 Arithmetic wrap of MAGIC - x[22:0] SHALL be modulo 2^23. Operands with exponents 7'h01 and 7'h7E are covered only by REQ-026 precision, with no special handling.

Reset
REQ-028 While rst is high:
  - state <= IDLE;
  - recip_valid = 0 and recip = 24'h000000;
  - iteration counter = 0 and busy = 0.
REQ-029 rst asserted in any state mid-operation SHALL abandon the operation with no result produced.
  - x_ready SHALL be high on the first edge after rst deasserts.
REQ-030 x_valid asserted in the same cycle as rst SHALL NOT be accepted.

Verification
REQ-031 x=24'h3F0000 (1.0) accepted, recip_ready=1 -> recip_valid rises exactly 9 cycles after accept; recip=24'h3F0000 ±2 LSB.
REQ-032 x=24'h400000 (2.0) -> recip=24'h3E0000 (0.5) ±2 LSB; x=24'hC10000 (-4.0) -> recip=24'hBD0000 (-0.25) ±2 LSB.
REQ-033 Special operands:
  - x=24'h000000 -> recip=24'h7F0000 after 9 cycles;
  - x=24'h800000 -> recip=24'hFF0000;
  - x=24'h7F0000 -> recip=24'h000000.
REQ-034 Backpressure: hold recip_ready=0 for 5 cycles after recip_valid rises -> recip stable and x_ready=0 throughout; one cycle after recip_ready=1, x_ready=1.
REQ-035 Reset mid-op: accept x=24'h400000, assert rst at cycle 4 -> recip_valid=0 and recip=0; new x=24'h410000 accepted after reset -> recip=24'h3D0000 ±2 LSB.
REQ-036 Protocol: x_valid held high with changing x during busy -> only the first value is used; exactly one result per accept.
